jh_external_sync_sram_responder: RTL and testbench

- Single-port synchronous SRAM model/responder for the external memory port of the interleaved sync FIFO.
- Services the FIFO's mem_addr/mem_din/mem_wr_enable/mem_rd_enable requests and returns mem_dout with a fixed, configurable read latency. The default latency of 2 matches the FIFO's two-stage prefetch valid pipeline.
- Adds protocol checking (illegal simultaneous read/write, out-of-range address) with sticky error flags, so FIFO-level benches can catch interface misuse.

---
 rtl/jh_external_sync_sram_responder.sv | 141 ++++++++++++++
 tb/tb_jh_external_sync_sram_responder.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jh_external_sync_sram_responder.sv
// Single-port sync SRAM responder for the FIFO external memory port.
// Optional even-parity protection per word under JH_SRAM_PARITY_EN.
module jh_external_sync_sram_responder #(
  parameter int DATA_WIDTH   = 8,
  parameter int FIFO_DEPTH   = 256,
  parameter int READ_LATENCY = 2,
  localparam int LB_FIFO_DEPTH = $clog2(FIFO_DEPTH)
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [LB_FIFO_DEPTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0]    mem_din,
  input  logic                     mem_wr_enable,
  input  logic                     mem_rd_enable,
  output logic [DATA_WIDTH-1:0]    mem_dout,
  output logic                     rd_valid,
  output logic                     err_rdwr,
  input  logic                     err_clear,
`ifdef JH_SRAM_PARITY_EN
  input  logic                     inject_parity_err,
  output logic                     err_parity,
`endif
  output logic                     err_addr
);

`ifdef JH_SRAM_PARITY_EN
  localparam int PW = 1;
`else
  localparam int PW = 0;
`endif
  localparam int SW = DATA_WIDTH + PW;

  logic [SW-1:0] mem_q [FIFO_DEPTH];

  logic [31:0]   addr_ext;
  logic          addr_ok;
  logic          wr_go;
  logic          rd_go;
  logic [SW-1:0] wr_word;
  logic [SW-1:0] rd_word;
  logic          last_v;
  logic [SW-1:0] last_d;

  assign addr_ext = 32'(mem_addr);
  assign addr_ok  = addr_ext < 32'(FIFO_DEPTH);
  assign wr_go    = mem_wr_enable & addr_ok;
  assign rd_go    = mem_rd_enable & ~mem_wr_enable;
  assign rd_word  = addr_ok ? mem_q[mem_addr] : '0;

`ifdef JH_SRAM_PARITY_EN
  assign wr_word = {(^mem_din) ^ inject_parity_err, mem_din};
`else
  assign wr_word = mem_din;
`endif

  always_ff @(posedge clk) begin
    if (wr_go) mem_q[mem_addr] <= wr_word;
  end

  // Stages between the array sample and the output register.
  generate
    if (READ_LATENCY == 1) begin : g_l1
      assign last_v = rd_go;
      assign last_d = rd_word;
    end else begin : g_pipe
      logic [READ_LATENCY-2:0] v_q;
      logic [SW-1:0]           d_q [READ_LATENCY-1];

      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          v_q <= '0;
          for (int k = 0; k < READ_LATENCY - 1; k++) d_q[k] <= '0;
        end else begin
          v_q[0] <= rd_go;
          d_q[0] <= rd_word;
          for (int k = 1; k < READ_LATENCY - 1; k++) begin
            v_q[k] <= v_q[k-1];
            d_q[k] <= d_q[k-1];
          end
        end
      end

      assign last_v = v_q[READ_LATENCY-2];
      assign last_d = d_q[READ_LATENCY-2];
    end
  endgenerate

  logic [DATA_WIDTH-1:0] dout_q;
  logic                  rd_valid_q;
  logic                  err_rdwr_q, err_rdwr_d;
  logic                  err_addr_q, err_addr_d;

  always_comb begin
    err_rdwr_d = err_rdwr_q;
    err_addr_d = err_addr_q;
    if (err_clear) begin
      err_rdwr_d = 1'b0;
      err_addr_d = 1'b0;
    end
    if (mem_wr_enable && mem_rd_enable) err_rdwr_d = 1'b1;
    if ((mem_wr_enable || mem_rd_enable) && !addr_ok) err_addr_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      dout_q     <= '0;
      rd_valid_q <= 1'b0;
      err_rdwr_q <= 1'b0;
      err_addr_q <= 1'b0;
    end else begin
      rd_valid_q <= last_v;
      if (last_v) dout_q <= last_d[DATA_WIDTH-1:0];
      err_rdwr_q <= err_rdwr_d;
      err_addr_q <= err_addr_d;
    end
  end

  assign mem_dout = dout_q;
  assign rd_valid = rd_valid_q;
  assign err_rdwr = err_rdwr_q;
  assign err_addr = err_addr_q;

`ifdef JH_SRAM_PARITY_EN
  logic err_par_q, err_par_d;

  // Stored word carries even parity, so a clean word XORs to zero.
  always_comb begin
    err_par_d = err_par_q;
    if (err_clear) err_par_d = 1'b0;
    if (last_v && (^last_d)) err_par_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) err_par_q <= 1'b0;
    else       err_par_q <= err_par_d;
  end

  assign err_parity = err_par_q;
`endif

endmodule

// File: tb/tb_jh_external_sync_sram_responder.sv
// Scoreboard bench for jh_external_sync_sram_responder.
// Expected read data is queued at issue time and checked on rd_valid.
module tb_jh_external_sync_sram_responder;
  localparam int DW    = 8;
  localparam int DEPTH = 200;
  localparam int RL    = 2;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic [7:0]    mem_addr = '0;
  logic [DW-1:0] mem_din = '0;
  logic          mem_wr_enable = 1'b0;
  logic          mem_rd_enable = 1'b0;
  logic          err_clear = 1'b0;
  logic [DW-1:0] mem_dout;
  logic          rd_valid;
  logic          err_rdwr;
  logic          err_addr;
`ifdef JH_SRAM_PARITY_EN
  logic          inject_parity_err = 1'b0;
  logic          err_parity;
`endif

  jh_external_sync_sram_responder #(
    .DATA_WIDTH(DW),
    .FIFO_DEPTH(DEPTH),
    .READ_LATENCY(RL)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .mem_addr(mem_addr),
    .mem_din(mem_din),
    .mem_wr_enable(mem_wr_enable),
    .mem_rd_enable(mem_rd_enable),
    .mem_dout(mem_dout),
    .rd_valid(rd_valid),
    .err_rdwr(err_rdwr),
    .err_clear(err_clear),
`ifdef JH_SRAM_PARITY_EN
    .inject_parity_err(inject_parity_err),
    .err_parity(err_parity),
`endif
    .err_addr(err_addr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [7:0] d;
    int         due;
  } exp_t;

  exp_t       sb[$];
  exp_t       mon_e;
  logic [7:0] mdl [256];

  always @(negedge clk) begin
    if (rstn && rd_valid) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_rd_valid cyc=%0d got dout=%h, required no pulse",
                 cyc, mem_dout);
      end else begin
        mon_e = sb.pop_front();
        if (mem_dout !== mon_e.d || cyc != mon_e.due) begin
          errors++;
          $display("FAIL read_data got %h at cyc %0d, required %h at cyc %0d",
                   mem_dout, cyc, mon_e.d, mon_e.due);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic drive(input logic w, input logic r, input logic [7:0] a,
                       input logic [7:0] d, input logic clr, input logic inj);
    @(posedge clk);
    #1;
    mem_wr_enable = w;
    mem_rd_enable = r;
    mem_addr      = a;
    mem_din       = d;
    err_clear     = clr;
`ifdef JH_SRAM_PARITY_EN
    inject_parity_err = inj;
`else
    if (inj) $display("inject ignored");
`endif
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 8'h0, 8'h0, 1'b0, 1'b0);
  endtask

  task automatic do_write(input logic [7:0] a, input logic [7:0] d);
    drive(1'b1, 1'b0, a, d, 1'b0, 1'b0);
    if (int'(a) < DEPTH) mdl[a] = d;
  endtask

  task automatic do_read(input logic [7:0] a);
    exp_t e;
    drive(1'b0, 1'b1, a, 8'h0, 1'b0, 1'b0);
    e.d   = (int'(a) < DEPTH) ? mdl[a] : 8'h00;
    e.due = cyc + RL;
    sb.push_back(e);
  endtask

  task automatic drain();
    repeat (RL + 3) idle();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d, required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks += 4;
    if (mem_dout !== 8'h00) begin
      errors++; $display("FAIL reset_dout got %h required 00", mem_dout);
    end
    if (rd_valid !== 1'b0) begin
      errors++; $display("FAIL reset_rd_valid got %b required 0", rd_valid);
    end
    if (err_rdwr !== 1'b0) begin
      errors++; $display("FAIL reset_err_rdwr got %b required 0", err_rdwr);
    end
    if (err_addr !== 1'b0) begin
      errors++; $display("FAIL reset_err_addr got %b required 0", err_addr);
    end
    @(posedge clk);
    #1 rstn = 1'b1;
  endtask

  task automatic test_write_read();
    do_write(8'd3, 8'hA5);
    do_read(8'd3);
    drain();
    checks += 2;
    if (mem_dout !== 8'hA5) begin
      errors++; $display("FAIL hold_dout got %h required a5", mem_dout);
    end
    if (rd_valid !== 1'b0) begin
      errors++; $display("FAIL hold_rd_valid got %b required 0", rd_valid);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) do_write(8'(i), 8'(8'h10 + i));
    for (int i = 0; i < 4; i++) do_read(8'(i));
    drain();
    for (int i = 0; i < 16; i++) do_write(8'(20 + i), 8'($urandom));
    for (int n = 0; n < 60; n++) begin
      int op;
      logic [7:0] a;
      op = $urandom_range(0, 2);
      a  = 8'(20 + $urandom_range(0, 15));
      if (op == 0)      do_write(a, 8'($urandom));
      else if (op == 1) do_read(a);
      else              idle();
    end
    drain();
  endtask

  task automatic test_rdwr();
    checks++;
    if (err_rdwr !== 1'b0) begin
      errors++; $display("FAIL rdwr_pre got %b required 0", err_rdwr);
    end
    drive(1'b1, 1'b1, 8'd5, 8'h77, 1'b0, 1'b0);
    mdl[5] = 8'h77;
    idle();
    checks++;
    if (err_rdwr !== 1'b1) begin
      errors++; $display("FAIL rdwr_set got %b required 1", err_rdwr);
    end
    drain();
    do_read(8'd5);
    drain();
    drive(1'b0, 1'b0, 8'd0, 8'h0, 1'b1, 1'b0);
    idle();
    checks++;
    if (err_rdwr !== 1'b0) begin
      errors++; $display("FAIL rdwr_clear got %b required 0", err_rdwr);
    end
    drive(1'b1, 1'b1, 8'd6, 8'h66, 1'b1, 1'b0);
    mdl[6] = 8'h66;
    idle();
    checks++;
    if (err_rdwr !== 1'b1) begin
      errors++; $display("FAIL rdwr_clear_race got %b required 1", err_rdwr);
    end
    do_read(8'd6);
    drain();
    drive(1'b0, 1'b0, 8'd0, 8'h0, 1'b1, 1'b0);
    idle();
  endtask

  task automatic test_addr();
    checks++;
    if (err_addr !== 1'b0) begin
      errors++; $display("FAIL addr_pre got %b required 0", err_addr);
    end
    do_write(8'd10, 8'h55);
    do_write(8'd210, 8'h99);
    idle();
    checks++;
    if (err_addr !== 1'b1) begin
      errors++; $display("FAIL addr_set got %b required 1", err_addr);
    end
    do_read(8'd10);
    do_read(8'd210);
    drain();
    drive(1'b0, 1'b0, 8'd0, 8'h0, 1'b1, 1'b0);
    idle();
    checks++;
    if (err_addr !== 1'b0) begin
      errors++; $display("FAIL addr_clear got %b required 0", err_addr);
    end
    drive(1'b0, 1'b1, 8'd199, 8'h0, 1'b0, 1'b0);
    sb.push_back('{d: mdl[199], due: cyc + RL});
    idle();
    checks++;
    if (err_addr !== 1'b0) begin
      errors++; $display("FAIL addr_edge got %b required 0", err_addr);
    end
    drain();
  endtask

  task automatic test_reset_midop();
    do_write(8'd4, 8'hC3);
    do_read(8'd4);
    drain();
    drive(1'b0, 1'b1, 8'd4, 8'h0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rstn = 1'b0;
    mem_rd_enable = 1'b0;
    sb.delete();
    #2;
    checks += 2;
    if (mem_dout !== 8'h00) begin
      errors++; $display("FAIL midrst_dout got %h required 00", mem_dout);
    end
    if (rd_valid !== 1'b0) begin
      errors++; $display("FAIL midrst_rd_valid got %b required 0", rd_valid);
    end
    @(posedge clk);
    #1 rstn = 1'b1;
    drain();
    checks++;
    if (mem_dout !== 8'h00) begin
      errors++; $display("FAIL postrst_dout got %h required 00", mem_dout);
    end
    do_read(8'd4);
    drain();
  endtask

`ifdef JH_SRAM_PARITY_EN
  task automatic test_parity();
    do_write(8'd8, 8'h3C);
    do_read(8'd8);
    drain();
    checks++;
    if (err_parity !== 1'b0) begin
      errors++; $display("FAIL parity_clean got %b required 0", err_parity);
    end
    drive(1'b1, 1'b0, 8'd7, 8'h3C, 1'b0, 1'b1);
    mdl[7] = 8'h3C;
    do_read(8'd7);
    drain();
    checks++;
    if (err_parity !== 1'b1) begin
      errors++; $display("FAIL parity_inject got %b required 1", err_parity);
    end
    drive(1'b0, 1'b0, 8'd0, 8'h0, 1'b1, 1'b0);
    idle();
    checks++;
    if (err_parity !== 1'b0) begin
      errors++; $display("FAIL parity_clear got %b required 0", err_parity);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_write_read();
    test_back_to_back();
    test_rdwr();
    test_addr();
    test_reset_midop();
`ifdef JH_SRAM_PARITY_EN
    test_parity();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
